// File: rtl/keccak_msg_feeder.sv
// Feeds hash commands and message words into the keccak core under buffer_full backpressure,
// then captures the digest and holds it for a valid/ready consumer.
`timescale 1ns/1ps
module keccak_msg_feeder #(
    parameter int IW = 128,
    parameter int BW = 4,
    parameter int LW = 16,
    parameter int DW = 224
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [LW-1:0] cmd_len,
    input  logic [IW-1:0] src_data,
    input  logic          src_valid,
    output logic          src_ready,
    output logic          k_reset,
    output logic [IW-1:0] k_in,
    output logic          k_in_ready,
    output logic          k_is_last,
    output logic [BW-1:0] k_byte_num,
    input  logic          k_buffer_full,
    input  logic [DW-1:0] k_out,
    input  logic          k_out_ready,
    output logic          dig_valid,
    output logic [DW-1:0] dig_data,
    input  logic          dig_ready
);

    typedef enum logic [2:0] {IDLE, CLR, FEED, LAST, WAIT, DONE} state_t;

    localparam logic [LW-BW-1:0] ONE_WORD = 1;

    state_t           state;
    state_t           next_state;
    logic [LW-BW-1:0] nfull;
    logic [BW-1:0]    rem;
    logic [IW-1:0]    keep_mask;

    // Keeps the first rem bytes (MSB side) of the final partial word.
    assign keep_mask = ~({IW{1'b1}} >> {rem, 3'b000});

    always_comb begin
        next_state = state;
        cmd_ready  = 1'b0;
        src_ready  = 1'b0;
        k_in       = '0;
        k_in_ready = 1'b0;
        k_is_last  = 1'b0;
        k_byte_num = '0;
        case (state)
            IDLE: begin
                cmd_ready = !k_reset;
                if (cmd_valid && !k_reset)
                    next_state = CLR;
            end
            CLR: begin
                next_state = (nfull != '0) ? FEED : LAST;
            end
            FEED: begin
                k_in       = src_data;
                k_in_ready = src_valid;
                src_ready  = src_valid && !k_buffer_full;
                if (src_ready && nfull == ONE_WORD)
                    next_state = LAST;
            end
            LAST: begin
                k_is_last = 1'b1;
                // An exact multiple of the word size still needs an empty terminating word.
                if (rem != '0) begin
                    k_in       = src_data & keep_mask;
                    k_in_ready = src_valid;
                    src_ready  = src_valid && !k_buffer_full;
                    k_byte_num = rem;
                end else begin
                    k_in_ready = 1'b1;
                end
                if (k_in_ready && !k_buffer_full)
                    next_state = WAIT;
            end
            WAIT: begin
                if (k_out_ready)
                    next_state = DONE;
            end
            DONE: begin
                if (dig_ready)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // k_reset is high out of reset and again for the single CLR cycle of each hash.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            k_reset   <= 1'b1;
            nfull     <= '0;
            rem       <= '0;
            dig_valid <= 1'b0;
            dig_data  <= '0;
        end else begin
            state   <= next_state;
            k_reset <= (next_state == CLR);
            if (state == IDLE && cmd_valid && cmd_ready) begin
                nfull <= cmd_len[LW-1:BW];
                rem   <= cmd_len[BW-1:0];
            end
            if (state == FEED && src_ready)
                nfull <= nfull - ONE_WORD;
            if (state == WAIT && k_out_ready) begin
                dig_data  <= k_out;
                dig_valid <= 1'b1;
            end
            if (state == DONE && dig_ready)
                dig_valid <= 1'b0;
        end
    end

endmodule
